// File: rtl/write_data_sel_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | write_data_sel_pkg : shared types and constants for write_data_sel       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package write_data_sel_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  localparam int CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/write_data_sel_skid_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | skid_buf : 2-entry skid buffer (main output register + skid register)    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module skid_buf
  import write_data_sel_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  buf_state_t       r_state;
  buf_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_from_in;
  logic             w_main_from_skid;
  logic             w_skid_from_in;

  // in_ready decodes only the state flop, so out_ready never reaches it combinationally
  assign in_ready   = (r_state != TWO);
  assign out_valid  = (r_state != EMPTY);
  assign out_data   = r_main;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_main_from_in = 1'b1;
          w_state_nxt    = ONE;
        end
      end
      ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_from_in = 1'b1;
        end else if (w_in_fire) begin
          w_skid_from_in = 1'b1;
          w_state_nxt    = TWO;
        end else if (w_out_fire) begin
          w_state_nxt    = EMPTY;
        end
      end
      TWO: begin
        if (w_out_fire) begin
          w_main_from_skid = 1'b1;
          w_state_nxt      = ONE;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_main_from_in) begin
        r_main <= in_data;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_from_in) begin
        r_skid <= in_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/write_data_sel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | write_data_sel : channel select into a skid-buffered output, with        |
// | illegal-select capture and output transfer counter.   Rev 1.0            |
// +--------------------------------------------------------------------------+
module write_data_sel
  import write_data_sel_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int N_SRC  = 8,
  parameter int N_USED = 7,
  localparam int SEL_W = ($clog2(N_SRC) > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   err_clr,
  output logic                   err_sticky,
  output logic [SEL_W-1:0]       err_sel,
  output logic [CNT_W-1:0]       xfer_cnt
);

  logic [WIDTH-1:0] w_word;
  logic             w_legal;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             r_err_sticky;
  logic [SEL_W-1:0] r_err_sel;
  logic [CNT_W-1:0] r_xfer_cnt;

  // Only the first N_USED channels are reachable; anything else yields zero
  always_comb begin
    w_word  = '0;
    w_legal = 1'b0;
    for (int k = 0; k < N_USED; k++) begin
      if (sel == SEL_W'(k)) begin
        w_word  = src_data[k*WIDTH +: WIDTH];
        w_legal = 1'b1;
      end
    end
  end

  skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (w_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sticky <= 1'b0;
      r_err_sel    <= '0;
      r_xfer_cnt   <= '0;
    end else begin
      if (err_clr) begin
        r_err_sticky <= 1'b0;
        r_err_sel    <= '0;
      end else if (w_in_fire && !w_legal && !r_err_sticky) begin
        r_err_sticky <= 1'b1;
        r_err_sel    <= sel;
      end
      if (w_out_fire) begin
        r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
      end
    end
  end

  assign err_sticky = r_err_sticky;
  assign err_sel    = r_err_sel;
  assign xfer_cnt   = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_write_data_sel.sv
`default_nettype none
// Self-checking bench for write_data_sel: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_write_data_sel;

  localparam int WIDTH  = 32;
  localparam int N_SRC  = 16;
  localparam int N_USED = 7;
  localparam int SEL_W  = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_SRC*WIDTH-1:0] src_data;
  logic [SEL_W-1:0]       sel;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   err_clr;
  logic                   err_sticky;
  logic [SEL_W-1:0]       err_sel;
  logic [15:0]            xfer_cnt;

  write_data_sel #(
    .WIDTH  (WIDTH),
    .N_SRC  (N_SRC),
    .N_USED (N_USED)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_data   (src_data),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_clr    (err_clr),
    .err_sticky (err_sticky),
    .err_sel    (err_sel),
    .xfer_cnt   (xfer_cnt)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [WIDTH-1:0] src [N_SRC];
  logic [WIDTH-1:0] q [$];
  logic             m_err;
  logic [SEL_W-1:0] m_esel;
  logic [15:0]      m_cnt;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    for (int k = 0; k < N_SRC; k++) src_data[k*WIDTH +: WIDTH] = src[k];
  endtask

  task automatic model_reset();
    q.delete();
    m_err  = 1'b0;
    m_esel = '0;
    m_cnt  = '0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'(q.size() < 2));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) check({tag, "_out_data"}, out_data, q[0]);
    check({tag, "_err_sticky"}, 32'(err_sticky), 32'(m_err));
    check({tag, "_err_sel"},    32'(err_sel),    32'(m_esel));
    check({tag, "_xfer_cnt"},   32'(xfer_cnt),   32'(m_cnt));
  endtask

  // One clock: model decides transfers from pre-edge inputs, DUT sampled 1ns after the edge.
  task automatic cycle(input string tag, input bit do_check);
    bit               ifire, ofire, legal;
    logic [WIDTH-1:0] word;
    drive_src();
    ifire = in_valid && (q.size() < 2);
    ofire = out_ready && (q.size() > 0);
    legal = (int'(sel) < N_USED);
    word  = legal ? src[sel] : '0;
    @(posedge clk);
    if (ofire) begin
      void'(q.pop_front());
      m_cnt = m_cnt + 16'd1;
    end
    if (ifire) q.push_back(word);
    if (err_clr) begin
      m_err  = 1'b0;
      m_esel = '0;
    end else if (ifire && !legal && !m_err) begin
      m_err  = 1'b1;
      m_esel = sel;
    end
    #1;
    if (do_check) check_model(tag);
  endtask

  initial begin
    int guard;
    for (int k = 0; k < N_SRC; k++) src[k] = $urandom;
    drive_src();
    sel = '0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    model_reset();

    // reset state
    rst_n = 1'b0;
    #12;
    check("rst_in_ready",   32'(in_ready),   32'd1);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_data",   out_data,        32'd0);
    check("rst_err_sticky", 32'(err_sticky), 32'd0);
    check("rst_err_sel",    32'(err_sel),    32'd0);
    check("rst_xfer_cnt",   32'(xfer_cnt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single word, one-cycle latency
    src[3] = 32'h0000_00E3; sel = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
    cycle("lat", 1'b1);
    check("lat_data", out_data, 32'h0000_00E3);
    check("lat_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    cycle("lat2", 1'b1);
    check("lat_cnt", 32'(xfer_cnt), 32'd1);

    // back-pressure fills both entries, then drains in order
    out_ready = 1'b0; in_valid = 1'b1;
    src[0] = 32'hA; sel = 4'd0; cycle("bp1", 1'b1);
    src[1] = 32'hB; sel = 4'd1; cycle("bp2", 1'b1);
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; cycle("bp_hold", 1'b1);
    check("bp_head", out_data, 32'hA);
    out_ready = 1'b1; cycle("bp_drain1", 1'b1);
    check("bp_second", out_data, 32'hB);
    check("bp_in_ready", 32'(in_ready), 32'd1);
    cycle("bp_drain2", 1'b1);

    // illegal selects: first one captured, later one ignored, then cleared
    in_valid = 1'b1; sel = 4'd7; cycle("ill7", 1'b1);
    check("ill7_data", out_data, 32'd0);
    check("ill7_err", 32'(err_sticky), 32'd1);
    check("ill7_esel", 32'(err_sel), 32'd7);
    sel = 4'd9; cycle("ill9", 1'b1);
    check("ill9_esel", 32'(err_sel), 32'd7);
    in_valid = 1'b0; err_clr = 1'b1; cycle("clr", 1'b1);
    check("clr_err", 32'(err_sticky), 32'd0);
    check("clr_esel", 32'(err_sel), 32'd0);

    // clear wins over a concurrent illegal accept
    in_valid = 1'b1; sel = 4'd8; cycle("clrpri", 1'b1);
    check("clrpri_err", 32'(err_sticky), 32'd0);
    err_clr = 1'b0; in_valid = 1'b0; cycle("clrpri_idle", 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N_SRC; k++) src[k] = $urandom;
      sel       = SEL_W'($urandom_range(0, 15));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 19) == 0);
      cycle("rnd", 1'b1);
    end

    // counter wrap: stream until 0xFFFF, then one more transfer
    err_clr = 1'b0; in_valid = 1'b1; out_ready = 1'b1; sel = 4'd2;
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      cycle("bulk", 1'b0);
      guard++;
    end
    check("wrap_pre", 32'(xfer_cnt), 32'h0000_FFFF);
    in_valid = 1'b0;
    cycle("wrap", 1'b1);
    check("wrap_zero", 32'(xfer_cnt), 32'h0);
    cycle("wrap_drain", 1'b1);

    // asynchronous reset while two words are buffered
    out_ready = 1'b0; in_valid = 1'b1;
    src[4] = 32'h1234_5678; sel = 4'd4; cycle("fill1", 1'b1);
    src[5] = 32'h9ABC_DEF0; sel = 4'd5; cycle("fill2", 1'b1);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_out_data",  out_data,       32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst1", 1'b1);
    cycle("post_rst2", 1'b1);
    check("post_rst_empty", 32'(out_valid), 32'd0);
    src[6] = 32'hCAFE_0006; sel = 4'd6; in_valid = 1'b1;
    cycle("post_rst_acc", 1'b1);
    check("post_rst_word", out_data, 32'hCAFE_0006);
    in_valid = 1'b0;
    cycle("post_rst_end", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/write_data_sel.md
WRITE_DATA_SEL -- requirements
Module: write_data_sel

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every source and of the output.
REQ-002 SHALL have parameter N_SRC, default 8, number of source channels (2..16).
REQ-003 SHALL have parameter N_USED, default 7, number of legal channels (1..N_SRC); sel >= N_USED is illegal.
REQ-004 SHALL derive localparam SEL_W = max(1, clog2(N_SRC)).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-007 src_data  in  N_SRC*WIDTH  flattened sources; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel  in  SEL_W  channel select, sampled with in_valid.
REQ-009 in_valid  in  1  request carries valid sel/src_data this cycle.
REQ-010 in_ready  out  1  block can accept a request this cycle.
REQ-011 out_data  out  WIDTH  selected word, registered.
REQ-012 out_valid  out  1  out_data is valid.
REQ-013 out_ready  in  1  consumer accepts out_data this cycle.
REQ-014 err_clr  in  1  clears err_sticky and err_sel.
REQ-015 err_sticky  out  1  set once any illegal sel has been accepted.
REQ-016 err_sel  out  SEL_W  sel value of the first illegal request since last clear.
REQ-017 xfer_cnt  out  16  count of completed output transfers.

Function
REQ-018 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-019 Accepted word SHALL be src_data channel sel for legal sel, all-zeros for illegal sel.
REQ-020 Latency SHALL be exactly one cycle: word accepted at edge N is on out_data with out_valid=1 after edge N, provided the output register is empty or draining.
REQ-021 Storage SHALL be a 2-entry skid buffer (main output register + skid register); in_ready SHALL equal !skid_full, registered (no combinational path out_ready->in_ready).
REQ-022 States: EMPTY (out_valid=0), ONE (main full, skid empty), TWO (both full).
REQ-023 EMPTY: accept -> ONE; no accept -> EMPTY.
REQ-024 ONE: accept without output transfer -> TWO (word to skid); accept with output transfer -> ONE (new word to main); output transfer only -> EMPTY; neither -> ONE.
REQ-025 TWO: in_ready=0; output transfer -> ONE with skid moved to main; otherwise hold.
REQ-026 out_data and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-027 Ordering SHALL be strictly FIFO; no word dropped or duplicated.
REQ-028 On accepting illegal sel with err_sticky=0, SHALL set err_sticky=1 and err_sel=sel next edge; later illegal requests SHALL not overwrite err_sel.
REQ-029 err_clr SHALL have priority over a simultaneous illegal accept: both outputs cleared, the concurrent error is lost.
REQ-030 xfer_cnt SHALL increment by 1 per output transfer and wrap 0xFFFF -> 0x0000.

Reset
REQ-031 While reset=0, asynchronously: state EMPTY, out_valid=0, out_data=0, skid register=0, in_ready=1, err_sticky=0, err_sel=0, xfer_cnt=0.
REQ-032 Reset asserted mid-operation SHALL discard buffered words; first acceptance possible on the first rising edge after reset deasserts.

Structure
REQ-033 A shared package SHALL hold the state enum (EMPTY/ONE/TWO) and the 16-bit counter width constant.
REQ-034 The 2-entry skid buffer SHALL be a sub-module skid_buf parametrised by WIDTH; selection, error capture and counter stay in write_data_sel.

Verification
REQ-035 Reset, then sel=3, src3=0x0000_00E3, in_valid=1, out_ready=1 -> next cycle out_data=0x0000_00E3, out_valid=1, xfer_cnt=1 one cycle later.
REQ-036 out_ready=0, send sel=0 (0xA), sel=1 (0xB) back-to-back -> in_ready=0 after second; out_ready=1 -> 0xA then 0xB on consecutive cycles, in_ready=1 again.
REQ-037 sel=7 (N_USED=7), then sel=9 with N_SRC=16 -> out_data=0, err_sticky=1, err_sel=7 retained; err_clr pulse -> err_sticky=0, err_sel=0.
REQ-038 err_clr=1 same cycle as illegal accept -> err_sticky stays 0.
REQ-039 Preload xfer_cnt to 0xFFFF via 65535 transfers, one more -> xfer_cnt=0x0000.
REQ-040 State TWO, assert reset=0 between edges -> out_valid=0, in_ready=1 immediately; no stale word appears after release.
